// File: rtl/ft232r_fifo_hs.sv
// FT232R UART bridge: 8N1 RX/TX with per-direction byte FIFOs, RTS/CTS flow control
// and 4-phase req/ack word interfaces toward the command and response logic.
module ft232r_fifo_hs #(
  parameter int unsigned P_CLK_FREQ_HZ = 100000000,
  parameter int unsigned P_BAUD_RATE   = 3000000,
  parameter int unsigned P_WORD_BYTES  = 1,
  parameter int unsigned P_DEPTH       = 16,
  parameter int unsigned P_CTS_MARGIN  = 4,
  parameter int unsigned P_TX_FLOW     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        txd,
  output logic                        rxd,
  input  logic                        rts_n,
  output logic                        cts_n,
  input  logic                        rsp_req,
  output logic                        rsp_ack,
  input  logic [8*P_WORD_BYTES-1:0]   rsp_data,
  output logic                        cmd_req,
  input  logic                        cmd_ack,
  output logic [8*P_WORD_BYTES-1:0]   cmd_data,
  output logic [$clog2(P_DEPTH):0]    rx_level,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int unsigned BitN = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam int unsigned CW   = $clog2(BitN + 1);
  localparam int unsigned AW   = $clog2(P_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned WW   = 8 * P_WORD_BYTES;

  localparam logic [CW-1:0] CntLast  = CW'(BitN - 1);
  localparam logic [CW-1:0] CntHalf  = CW'(BitN / 2 - 1);
  localparam logic [LW-1:0] LvlFull  = LW'(P_DEPTH);
  localparam logic [LW-1:0] LvlCts   = LW'(P_DEPTH - P_CTS_MARGIN);
  localparam logic [LW-1:0] LvlWord  = LW'(P_WORD_BYTES);
  localparam logic [LW-1:0] LvlTxMax = LW'(P_DEPTH - P_WORD_BYTES);
  localparam logic [2:0]    IdxLast  = 3'(P_WORD_BYTES - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {CmdIdle, CmdLoad, CmdReq, CmdWack} cmd_state_e;
  typedef enum logic [1:0] {RspIdle, RspWspace, RspPush, RspAck} rsp_state_e;

  // Input synchronisers
  logic txd_meta_q, txd_sync_q, txd_prev_q, rts_meta_q, rts_sync_q;

  // UART receiver
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_push, overflow_q, overflow_d, frame_err_q, frame_err_d;

  // RX FIFO
  logic [7:0]    rx_mem [P_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [LW-1:0] rx_count_q, rx_count_d;
  logic          rx_pop, rx_wr_ok;
  logic [7:0]    rx_rdata;
  logic          cts_n_q;

  // Command word FSM
  cmd_state_e    cmd_state_q, cmd_state_d;
  logic [2:0]    cmd_idx_q, cmd_idx_d;
  logic [WW-1:0] cmd_data_q, cmd_data_d;

  // Response word FSM
  rsp_state_e    rsp_state_q, rsp_state_d;
  logic [2:0]    rsp_idx_q, rsp_idx_d;
  logic [WW-1:0] rsp_word_q, rsp_word_d;
  logic          rsp_req_prev_q;
  logic          tx_push;
  logic [7:0]    tx_wdata;

  // TX FIFO and serializer
  logic [7:0]    tx_mem [P_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [LW-1:0] tx_count_q, tx_count_d;
  logic          tx_pop, tx_flow_ok, tx_end;
  logic [7:0]    tx_rdata;
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;

  assign rx_rdata = rx_mem[rx_rptr_q];
  assign tx_rdata = tx_mem[tx_rptr_q];
  // A full FIFO can still take a byte in the same cycle the command FSM pops one.
  assign rx_wr_ok = (rx_count_q != LvlFull) || rx_pop;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push     = 1'b0;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (txd_prev_q && !txd_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = txd_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d = '0;
          rx_sh_d  = {txd_sync_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_state_d = RxIdle;
          if (!txd_sync_q)   frame_err_d = 1'b1;
          else if (rx_wr_ok) rx_push     = 1'b1;
          else               overflow_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    cmd_state_d = cmd_state_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_data_d  = cmd_data_q;
    rx_pop      = 1'b0;
    cmd_req     = 1'b0;
    unique case (cmd_state_q)
      CmdIdle: begin
        if (rx_count_q >= LvlWord) begin
          cmd_state_d = CmdLoad;
          cmd_idx_d   = '0;
        end
      end
      CmdLoad: begin
        rx_pop = 1'b1;
        for (int i = 0; i < int'(P_WORD_BYTES); i++) begin
          if (cmd_idx_q == 3'(i)) cmd_data_d[8*i +: 8] = rx_rdata;
        end
        if (cmd_idx_q == IdxLast) cmd_state_d = CmdReq;
        else                      cmd_idx_d   = cmd_idx_q + 1'b1;
      end
      CmdReq: begin
        cmd_req = 1'b1;
        if (cmd_ack) cmd_state_d = CmdWack;
      end
      CmdWack: begin
        if (!cmd_ack) cmd_state_d = CmdIdle;
      end
      default: cmd_state_d = CmdIdle;
    endcase
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_word_d  = rsp_word_q;
    tx_push     = 1'b0;
    tx_wdata    = '0;
    rsp_ack     = 1'b0;
    unique case (rsp_state_q)
      RspIdle: begin
        if (rsp_req && !rsp_req_prev_q) begin
          rsp_word_d  = rsp_data;
          rsp_state_d = RspWspace;
        end
      end
      RspWspace: begin
        if (tx_count_q <= LvlTxMax) begin
          rsp_state_d = RspPush;
          rsp_idx_d   = '0;
        end
      end
      RspPush: begin
        tx_push = 1'b1;
        for (int i = 0; i < int'(P_WORD_BYTES); i++) begin
          if (rsp_idx_q == 3'(i)) tx_wdata = rsp_word_q[8*i +: 8];
        end
        if (rsp_idx_q == IdxLast) rsp_state_d = RspAck;
        else                      rsp_idx_d   = rsp_idx_q + 1'b1;
      end
      RspAck: begin
        rsp_ack = 1'b1;
        if (!rsp_req) rsp_state_d = RspIdle;
      end
      default: rsp_state_d = RspIdle;
    endcase
  end

  // The next byte is popped in the last cycle of the stop bit so frames run back-to-back.
  assign tx_flow_ok = (P_TX_FLOW == 0) || !rts_sync_q;
  assign tx_end     = tx_busy_q && (tx_cnt_q == CntLast) && (tx_bit_q == 4'd9);
  assign tx_pop     = (tx_count_q != '0) && tx_flow_ok && (!tx_busy_q || tx_end);

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    if (tx_pop) begin
      tx_busy_d = 1'b1;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_sh_d   = {1'b1, tx_rdata, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CntLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_sh_q;
    if (tx_push) tx_mem[tx_wptr_q] <= tx_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_meta_q     <= 1'b1;
      txd_sync_q     <= 1'b1;
      txd_prev_q     <= 1'b1;
      rts_meta_q     <= 1'b1;
      rts_sync_q     <= 1'b1;
      rx_state_q     <= RxIdle;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_sh_q        <= '0;
      overflow_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      rx_wptr_q      <= '0;
      rx_rptr_q      <= '0;
      rx_count_q     <= '0;
      cts_n_q        <= 1'b0;
      cmd_state_q    <= CmdIdle;
      cmd_idx_q      <= '0;
      cmd_data_q     <= '0;
      rsp_state_q    <= RspIdle;
      rsp_idx_q      <= '0;
      rsp_word_q     <= '0;
      rsp_req_prev_q <= 1'b0;
      tx_wptr_q      <= '0;
      tx_rptr_q      <= '0;
      tx_count_q     <= '0;
      tx_busy_q      <= 1'b0;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_sh_q        <= '1;
    end else begin
      txd_meta_q     <= txd;
      txd_sync_q     <= txd_meta_q;
      txd_prev_q     <= txd_sync_q;
      rts_meta_q     <= rts_n;
      rts_sync_q     <= rts_meta_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_sh_q        <= rx_sh_d;
      overflow_q     <= overflow_d;
      frame_err_q    <= frame_err_d;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_count_q     <= rx_count_d;
      cts_n_q        <= (rx_count_q >= LvlCts);
      cmd_state_q    <= cmd_state_d;
      cmd_idx_q      <= cmd_idx_d;
      cmd_data_q     <= cmd_data_d;
      rsp_state_q    <= rsp_state_d;
      rsp_idx_q      <= rsp_idx_d;
      rsp_word_q     <= rsp_word_d;
      rsp_req_prev_q <= rsp_req;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_count_q     <= tx_count_d;
      tx_busy_q      <= tx_busy_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_sh_q        <= tx_sh_d;
    end
  end

  // Idle line is high; reset clears tx_busy_q asynchronously so rxd recovers at once.
  assign rxd       = tx_busy_q ? tx_sh_q[0] : 1'b1;
  assign cts_n     = cts_n_q;
  assign cmd_data  = cmd_data_q;
  assign rx_level  = rx_count_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
